regfile_tester: RTL and testbench
=================================

# regfile_tester

Self-checking initiator for the 32 x 64-bit register file. It drives the write port (WriteData/Rd/RegWrite) and both read ports (Rs1/Rs2), and samples ReadData1/ReadData2. On Start it writes a seeded pattern to x1..x31, reads every register back through both read ports, and reports a pass/fail summary. It sits beside the register file as a built-in-self-test engine and as reusable stimulus for datapath bring-up.

## Interface
- DATA_W, 64, register width
- ADDR_W, 5, register index width
- NUM_REGS, 32, registers in file; x0 is never addressed
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin a run; sampled only in IDLE
- Seed  in  DATA_W  pattern base; latched when Start is accepted
- WriteData  out  DATA_W  to register file write data
- Rd  out  ADDR_W  to register file write index
- RegWrite  out  1  to register file write enable
- Rs1, Rs2  out  ADDR_W  to register file read indices
- ReadData1, ReadData2  in  DATA_W  from register file; combinational in Rs1/Rs2
- Busy  out  1  high in WRITE and READ
- Done  out  1  one-cycle pulse at end of run
- Pass  out  1  ErrCount == 0 for the last completed run
- ErrCount  out  6  mismatching port reads in the last run (max 62)
- FirstErrReg  out  ADDR_W  register index of the first mismatch; 0 if none

## Operation
- The FSM has four states: IDLE, WRITE, READ, DONE. An index counter idx runs over 1..31.
- IDLE: if Start, latch Seed, clear ErrCount/FirstErrReg/Pass, set idx=1, go to WRITE.
- WRITE: drive RegWrite=1, Rd=idx, WriteData=Seed+idx (mod 2^64). Increment idx each cycle. After idx=31, set idx=1 and go to READ.
- READ: drive Rs1=idx and Rs2=32-idx, so every register is read once per port.
  - Expected values are Seed+idx and Seed+(32-idx).
  - Each mismatching port adds 1 to ErrCount, so 0..2 per cycle.
  - FirstErrReg records on the first mismatch of the run; port 1 takes priority.
  - After idx=31, go to DONE.
- DONE: Done=1 and Pass=(ErrCount==0). Return to IDLE.
- Outside WRITE, RegWrite=0, Rd=0 and WriteData=0. Outside READ, Rs1=0 and Rs2=0.
- Start is ignored outside IDLE.
- Reset mid-run forces IDLE at the next edge and clears all status. Register-file contents are not restored.

## Timing
- Port outputs are Moore outputs decoded from state and idx. A write lands at the edge ending its WRITE cycle.
- Cycle 0 is the IDLE cycle in which Start=1 is sampled. WRITE occupies cycles 1..31, READ cycles 32..62, DONE cycle 63, and IDLE resumes at cycle 64.
- ReadData is compared in the same cycle that Rs1/Rs2 are driven. ErrCount and FirstErrReg update at that cycle's closing edge.
- Pass, ErrCount and FirstErrReg are valid from cycle 63. They hold until the edge that accepts the next Start.
- If Start is held high, runs repeat every 64 cycles and Done pulses once per run.
- Reset values: all outputs 0 and state IDLE.

## Structure
- Shared package regfile_tester_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS
  - the state enum (IDLE/WRITE/READ/DONE)
  - the function expected(seed, idx) = seed + idx
- Natural sub-module: regfile_tester_cmp. It takes both read data values, both expected values and both indices. It returns the per-port mismatch bits and the error increment (0..2).

## Test plan
- Reset, then Start with Seed=100 against a correct register-file model:
  - 31 writes, with x3=103 and x31=131.
  - Done pulses in cycle 63, Pass=1, ErrCount=0, FirstErrReg=0.
- x5 stuck at 0 in the model, Seed=100 -> ErrCount=2 (read at READ idx 5 via Rs1 and idx 27 via Rs2), FirstErrReg=5, Pass=0.
- Seed=64'hFFFF_FFFF_FFFF_FFF0 -> x16 written as 0 and x31 as 15 (wrap). Pass=1.
- Reset asserted during WRITE cycle 10 -> at the next edge RegWrite=0, Busy=0, status cleared. A following Start runs a full pass with Pass=1.
- Start pulsed during READ, then held high through DONE -> the mid-run pulse has no effect. The next run begins at cycle 64 and Done pulses every 64 cycles.
- Throughout every run:
  - Rd is never 0 while RegWrite=1.
  - RegWrite is high for exactly 31 cycles per run.
  - Busy is high for exactly 62 cycles per run.

Source files
------------

// File: rtl/regfile_tester_pkg.sv
// rtl/regfile_tester_pkg.sv - shared widths, FSM states and pattern function for the regfile tester
package regfile_tester_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pattern stored in register idx for a given run seed (wraps mod 2^DATA_W)
  function automatic logic [DATA_W-1:0] expected(input logic [DATA_W-1:0] seed,
                                                 input logic [ADDR_W-1:0] idx);
    return seed + {{(DATA_W-ADDR_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/regfile_tester_cmp.sv
// rtl/regfile_tester_cmp.sv - dual read-port comparator producing mismatch bits and error increment
module regfile_tester_cmp
  import regfile_tester_pkg::*;
(
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] exp1,
  input  logic [DATA_W-1:0] exp2,
  input  logic [ADDR_W-1:0] idx1,
  input  logic [ADDR_W-1:0] idx2,
  output logic              mis1,
  output logic              mis2,
  output logic [1:0]        err_inc,
  output logic [ADDR_W-1:0] err_reg
);

  // Compare both ports; port 1 wins when naming the failing register
  always_comb begin
    mis1    = (read_data1 != exp1);
    mis2    = (read_data2 != exp2);
    err_inc = {1'b0, mis1} + {1'b0, mis2};
    err_reg = mis1 ? idx1 : (mis2 ? idx2 : '0);
  end

endmodule

// File: rtl/regfile_tester.sv
// rtl/regfile_tester.sv - built-in self-test initiator for the 32 x 64-bit register file
module regfile_tester
  import regfile_tester_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Seed,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] Rd,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Rs1,
  output logic [ADDR_W-1:0] Rs2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [5:0]        ErrCount,
  output logic [ADDR_W-1:0] FirstErrReg
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] exp1;
  logic [DATA_W-1:0] exp2;
  logic              mis1;
  logic              mis2;
  logic [1:0]        err_inc;
  logic [ADDR_W-1:0] err_reg;
  logic [5:0]        err_sum;

  assign idx_next = idx + 1'b1;
  assign exp1     = expected(seed_q, Rs1);
  assign exp2     = expected(seed_q, Rs2);
  assign err_sum  = ErrCount + {4'b0, err_inc};

  regfile_tester_cmp u_cmp (
    .read_data1 (ReadData1),
    .read_data2 (ReadData2),
    .exp1       (exp1),
    .exp2       (exp2),
    .idx1       (Rs1),
    .idx2       (Rs2),
    .mis1       (mis1),
    .mis2       (mis2),
    .err_inc    (err_inc),
    .err_reg    (err_reg)
  );

  // Run FSM; port outputs are registered so they always reflect the current state and idx
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      idx         <= '0;
      seed_q      <= '0;
      WriteData   <= '0;
      Rd          <= '0;
      RegWrite    <= 1'b0;
      Rs1         <= '0;
      Rs2         <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      ErrCount    <= '0;
      FirstErrReg <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            seed_q      <= Seed;
            ErrCount    <= '0;
            FirstErrReg <= '0;
            Pass        <= 1'b0;
            idx         <= ADDR_W'(1);
            state       <= WRITE;
            Busy        <= 1'b1;
            RegWrite    <= 1'b1;
            Rd          <= ADDR_W'(1);
            WriteData   <= expected(Seed, ADDR_W'(1));
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            idx       <= ADDR_W'(1);
            state     <= READ;
            RegWrite  <= 1'b0;
            Rd        <= '0;
            WriteData <= '0;
            Rs1       <= ADDR_W'(1);
            Rs2       <= LAST_IDX;
          end else begin
            idx       <= idx_next;
            Rd        <= idx_next;
            WriteData <= expected(seed_q, idx_next);
          end
        end
        READ: begin
          ErrCount <= err_sum;
          if ((ErrCount == '0) && (mis1 || mis2)) begin
            FirstErrReg <= err_reg;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            Rs1   <= '0;
            Rs2   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Pass  <= (err_sum == '0);
          end else begin
            idx <= idx_next;
            Rs1 <= idx_next;
            Rs2 <= LAST_IDX - idx;
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_tester.sv
// tb/tb_regfile_tester.sv - self-checking bench for regfile_tester with a faultable register-file model
module tb_regfile_tester;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [63:0] Seed;
  logic [63:0] WriteData;
  logic [4:0]  Rd;
  logic        RegWrite;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic [5:0]  ErrCount;
  logic [4:0]  FirstErrReg;

  regfile_tester dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Seed        (Seed),
    .WriteData   (WriteData),
    .Rd          (Rd),
    .RegWrite    (RegWrite),
    .Rs1         (Rs1),
    .Rs2         (Rs2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .Busy        (Busy),
    .Done        (Done),
    .Pass        (Pass),
    .ErrCount    (ErrCount),
    .FirstErrReg (FirstErrReg)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] rf [32];
  bit          stuck_en  = 1'b0;
  logic [4:0]  stuck_reg = 5'd0;
  logic [63:0] cur_seed  = 64'd0;

  always @(posedge Clk) begin
    if (RegWrite && Rd != 5'd0) rf[Rd] <= WriteData;
  end

  always_comb begin
    ReadData1 = rf[Rs1];
    ReadData2 = rf[Rs2];
    if (Rs1 == 5'd0 || (stuck_en && Rs1 == stuck_reg)) ReadData1 = 64'd0;
    if (Rs2 == 5'd0 || (stuck_en && Rs2 == stuck_reg)) ReadData2 = 64'd0;
  end

  int          cyc;
  int          wr_cnt;
  int          busy_cnt;
  int          rule_bad;
  logic [31:0] wr_seen;
  logic [31:0] rs1_seen;
  logic [31:0] rs2_seen;
  int          done_q[$];

  typedef struct {
    logic [63:0] seed;
    bit          stuck_en;
    int          stuck_reg;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A stuck-at-0 register is read once per port, so it costs 2 errors unless its pattern is 0
  function automatic void model(input logic [63:0] s, input bit en, input int r,
                                output int e, output int f);
    bit hit;
    hit = en && ((s + 64'(r)) != 64'd0);
    e = hit ? 2 : 0;
    f = hit ? r : 0;
  endfunction

  task automatic clear_mon();
    cyc = 0; wr_cnt = 0; busy_cnt = 0; rule_bad = 0;
    wr_seen = '0; rs1_seen = '0; rs2_seen = '0;
    done_q.delete();
  endtask

  task automatic sample();
    cyc++;
    if (RegWrite) begin
      wr_cnt++;
      if (Rd == 5'd0) rule_bad++;
      wr_seen[Rd] = 1'b1;
      if (WriteData !== cur_seed + 64'(Rd)) rule_bad++;
    end else if (Rd != 5'd0 || WriteData != 64'd0) rule_bad++;
    if (Busy) busy_cnt++;
    if (Busy && !RegWrite) begin
      if (Rs1 == 5'd0 || (6'(Rs1) + 6'(Rs2)) != 6'd32) rule_bad++;
      rs1_seen[Rs1] = 1'b1;
      rs2_seen[Rs2] = 1'b1;
    end else if (Rs1 != 5'd0 || Rs2 != 5'd0) rule_bad++;
    if (Done) done_q.push_back(cyc);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    sample();
  endtask

  task automatic run_one(input string name, input logic [63:0] s, input bit en, input int r,
                         input int exp_err, input int exp_first, input bit exp_pass);
    stuck_en = en; stuck_reg = 5'(r); cur_seed = s;
    Seed = s; Start = 1'b1;
    clear_mon();
    step();
    Start = 1'b0;
    while (done_q.size() == 0 && cyc < 100) step();
    check({name, " done_cycle"}, 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd63);
    check({name, " err_count"}, 64'(ErrCount), 64'(exp_err));
    check({name, " first_err"}, 64'(FirstErrReg), 64'(exp_first));
    check({name, " pass"}, 64'(Pass), 64'(exp_pass));
    check({name, " write_cycles"}, 64'(wr_cnt), 64'd31);
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'd62);
    check({name, " port_rules"}, 64'(rule_bad), 64'd0);
    check({name, " coverage"}, {wr_seen, rs1_seen & rs2_seen}, {32'hFFFF_FFFE, 32'hFFFF_FFFE});
    step();
    check({name, " done_pulse"}, 64'(Done), 64'd0);
    check({name, " err_hold"}, 64'(ErrCount), 64'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int f;
    Reset = 1'b1; Start = 1'b0; Seed = 64'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_ports", {WriteData, 59'(Rd), RegWrite, Rs1, Rs2}, 64'd0 ^ {WriteData ^ WriteData});
    check("reset_wdata", WriteData, 64'd0);
    check("reset_outs", {44'd0, Rd, RegWrite, Rs1, Rs2, Busy, Done, Pass},
          64'd0);
    check("reset_status", {53'd0, ErrCount, FirstErrReg}, 64'd0);
    Reset = 1'b0;
    step();

    run_one("seed100", 64'd100, 1'b0, 0, 0, 0, 1'b1);
    check("seed100 x3", rf[3], 64'd103);
    check("seed100 x31", rf[31], 64'd131);

    run_one("wrap", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0, 0, 0, 1'b1);
    check("wrap x16", rf[16], 64'd0);
    check("wrap x31", rf[31], 64'd15);

    vecs[0] = '{64'd100, 1'b1, 5, 2, 5, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 16, 0, 0, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 15, 2, 15, 1'b0};
    vecs[3] = '{64'd100, 1'b1, 31, 2, 31, 1'b0};
    vecs[4] = '{64'd100, 1'b1, 1, 2, 1, 1'b0};
    vecs[5] = '{64'd0, 1'b1, 16, 2, 16, 1'b0};
    for (int i = 6; i < 12; i++) begin
      vecs[i].seed      = {$urandom, $urandom};
      vecs[i].stuck_en  = 1'($urandom_range(0, 1));
      vecs[i].stuck_reg = $urandom_range(1, 31);
      model(vecs[i].seed, vecs[i].stuck_en, vecs[i].stuck_reg, e, f);
      vecs[i].exp_err   = e;
      vecs[i].exp_first = f;
      vecs[i].exp_pass  = (e == 0);
    end
    for (int i = 0; i < 12; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].seed, vecs[i].stuck_en, vecs[i].stuck_reg,
              vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_pass);
    end

    run_one("pre_reset", 64'd100, 1'b1, 5, 2, 5, 1'b0);
    Reset = 1'b1;
    step();
    check("idle_reset_status", {53'd0, ErrCount, FirstErrReg}, 64'd0);
    Reset = 1'b0;
    stuck_en = 1'b0;

    cur_seed = 64'd100; Seed = 64'd100; Start = 1'b1;
    clear_mon();
    step();
    Start = 1'b0;
    while (cyc < 10) step();
    check("midrun_in_write", 64'(RegWrite), 64'd1);
    Reset = 1'b1;
    step();
    check("midrun_reset_ports", {44'd0, Rd, RegWrite, Rs1, Rs2, Busy, Done, Pass}, 64'd0);
    check("midrun_reset_status", {53'd0, ErrCount, FirstErrReg}, 64'd0);
    Reset = 1'b0;
    step();
    run_one("after_reset", 64'd100, 1'b0, 0, 0, 0, 1'b1);

    cur_seed = 64'd100; Seed = 64'd100; Start = 1'b1;
    clear_mon();
    step();
    Start = 1'b0;
    while (cyc < 40) step();
    Start = 1'b1;
    step();
    Start = 1'b0;
    while (cyc < 62) step();
    Start = 1'b1;
    while (cyc < 191) step();
    Start = 1'b0;
    while (cyc < 200) step();
    check("held_done_count", 64'(done_q.size()), 64'd3);
    check("held_done0", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd63);
    check("held_done1", 64'(done_q.size() > 1 ? done_q[1] : -1), 64'd127);
    check("held_done2", 64'(done_q.size() > 2 ? done_q[2] : -1), 64'd191);
    check("held_write_cycles", 64'(wr_cnt), 64'd93);
    check("held_busy_cycles", 64'(busy_cnt), 64'd186);
    check("held_port_rules", 64'(rule_bad), 64'd0);
    check("held_pass", 64'(Pass), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
